// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// CTRL bit positions and the MTIMECMP reset value.
package dmem_pkg;

    // Byte offsets inside the 32-byte MMIO block
    localparam logic [4:0] OFF_MTIME    = 5'h00;
    localparam logic [4:0] OFF_MTIMECMP = 5'h04;
    localparam logic [4:0] OFF_CTRL     = 5'h08;
    localparam logic [4:0] OFF_TOHOST   = 5'h0C;
    localparam logic [4:0] OFF_CYCLE    = 5'h10;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_PEND   = 1;
    localparam int unsigned CTRL_RELOAD = 2;

    // Compare value out of reset: effectively "never" until software programs it
    localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-side bus: store strobe, byte address, store data and load data.
interface dmem_responder_if;

    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite,
        output ALUResult,
        output WriteData,
        input  ReadData
    );

    modport slave (
        input  MemWrite,
        input  ALUResult,
        input  WriteData,
        output ReadData
    );

endinterface

// File: rtl/dmem_timer.sv
// Programmable timer: MTIME counter, MTIMECMP compare, CTRL (EN/PEND/RELOAD).
// PEND is a register, so irq_o has no combinational path from the bus.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mtime_we_i,
    input  logic        mtimecmp_we_i,
    input  logic        ctrl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] mtime_o,
    output logic [31:0] mtimecmp_o,
    output logic [31:0] ctrl_o,
    output logic        irq_o
);

    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic        reload_q, reload_d;
    logic        match;

    // Next-state: an MTIME write beats counting; a compare match beats a PEND clear
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        pend_d     = pend_q;
        reload_d   = reload_q;
        match      = 1'b0;

        if (mtimecmp_we_i) begin
            mtimecmp_d = wdata_i;
        end

        if (ctrl_we_i) begin
            en_d     = wdata_i[CTRL_EN];
            reload_d = wdata_i[CTRL_RELOAD];
            if (wdata_i[CTRL_PEND]) begin
                pend_d = 1'b0;
            end
        end

        if (mtime_we_i) begin
            mtime_d = wdata_i;
        end else if (en_q) begin
            match = (mtime_q == mtimecmp_q);
            if (match && reload_q) begin
                mtime_d = '0;
            end else begin
                mtime_d = mtime_q + 32'd1;
            end
        end

        if (match) begin
            pend_d = 1'b1;
        end
    end

    // Timer state with synchronous reset that overrides any concurrent write
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            en_q       <= 1'b0;
            pend_q     <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            reload_q   <= reload_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign ctrl_o     = {29'd0, reload_q, pend_q, en_q};
    assign irq_o      = pend_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM, timer/tohost
// MMIO block and unmapped-write detection. Reads are combinational.
// Optional build macro DMEM_CYCLE_COUNTER_EN adds a read-only free-running
// CYCLE counter at MMIO offset 0x10.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              timer_irq,
    output logic              halt,
    output logic [31:0]       tohost,
    output logic              bus_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_LIMIT = 33'(DEPTH) * 33'd4;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] ram_idx;
    logic          ram_sel;
    logic          mmio_sel;
    logic [4:0]    mmio_off;
    logic          mmio_we;
    logic [31:0]   rdata;

    logic [31:0]   tohost_q;
    logic          halt_q;
    logic          bus_err_q;

    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic [31:0]   ctrl;
    logic [31:0]   cycle_rd;

    logic          unused_addr_lsb;

    assign ram_sel  = ({1'b0, bus.ALUResult} < RAM_LIMIT);
    assign mmio_sel = !ram_sel && (bus.ALUResult[31:5] == MMIO_BASE[31:5]);
    assign ram_idx  = bus.ALUResult[AW+1:2];
    // Byte lanes are ignored: every access is a full word
    assign mmio_off = {bus.ALUResult[4:2], 2'b00};
    assign mmio_we  = bus.MemWrite && mmio_sel;

    assign unused_addr_lsb = ^bus.ALUResult[1:0];

    dmem_timer u_timer (
        .clk           (clk),
        .reset         (reset),
        .mtime_we_i    (mmio_we && (mmio_off == OFF_MTIME)),
        .mtimecmp_we_i (mmio_we && (mmio_off == OFF_MTIMECMP)),
        .ctrl_we_i     (mmio_we && (mmio_off == OFF_CTRL)),
        .wdata_i       (bus.WriteData),
        .mtime_o       (mtime),
        .mtimecmp_o    (mtimecmp),
        .ctrl_o        (ctrl),
        .irq_o         (timer_irq)
    );

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    // Free-running cycle counter; bus writes never reach it
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    // RAM write port; contents are not reset, but reset blocks stores
    always_ff @(posedge clk) begin
        if (!reset && bus.MemWrite && ram_sel) begin
            mem[ram_idx] <= bus.WriteData;
        end
    end

    // TOHOST/halt and one-cycle bus_err pulse for stores that hit nothing
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_q  <= '0;
            halt_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus.MemWrite && !ram_sel && !mmio_sel;
            if (mmio_we && (mmio_off == OFF_TOHOST)) begin
                tohost_q <= bus.WriteData;
                if (bus.WriteData != 32'd0) begin
                    halt_q <= 1'b1;
                end
            end
        end
    end

    // Combinational load path: RAM, then MMIO, else zero
    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = mem[ram_idx];
        end else if (mmio_sel) begin
            case (mmio_off)
                OFF_MTIME:    rdata = mtime;
                OFF_MTIMECMP: rdata = mtimecmp;
                OFF_CTRL:     rdata = ctrl;
                OFF_TOHOST:   rdata = tohost_q;
                OFF_CYCLE:    rdata = cycle_rd;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign tohost       = tohost_q;
    assign halt         = halt_q;
    assign bus_err      = bus_err_q;

endmodule
